way_hit_profiler: RTL and testbench
===================================

WAY_HIT_PROFILER -- requirements
Module: way_hit_profiler

Interface
REQ-001 SHALL have parameter SINGLE_WAY_WIDTH_IN_BITS, default 4, width of one per-way hit count.
REQ-002 SHALL have parameter NUM_WAY, default 16, number of ways; power of 2, >= 2.
REQ-003 SHALL have parameter EPOCH_CYCLES, default 1024, enabled cycles per profiling epoch; >= SORT_LATENCY+1.
REQ-004 SHALL have parameter SORT_LATENCY, default 3, register stages of the downstream sorter.
REQ-005 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-007 SHALL have port access_valid_in, input, 1, one cache hit this cycle.
REQ-008 SHALL have port access_way_in, input, log2(NUM_WAY), way index of the hit.
REQ-009 SHALL have port enable_in, input, 1, profiling enabled.
REQ-010 SHALL have port restart_in, input, 1, abandon the current epoch.
REQ-011 SHALL have port pre_sort_flatted_out, output, SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY, epoch snapshot fed to the sorter; way i at bits [i*W +: W].
REQ-012 SHALL have port snapshot_valid_out, output, 1, one-cycle pulse on snapshot update.
REQ-013 SHALL have port sorted_valid_out, output, 1, one-cycle pulse marking the sorter output valid.

Function
REQ-014 SHALL keep one hit counter per way, W bits, saturating at 2^W-1 (no wrap).
REQ-015 SHALL increment counter[access_way_in] when access_valid_in=1 and enable_in=1; with enable_in=0, accesses are ignored.
REQ-016 SHALL keep an epoch counter 0..EPOCH_CYCLES-1, advancing only when enable_in=1; all counters hold while enable_in=0.
REQ-017 SHALL, on the enabled cycle the epoch counter equals EPOCH_CYCLES-1 (terminal cycle), load the snapshot register with all hit counters including that cycle's access, then clear all hit counters and the epoch counter.
REQ-018 SHALL update pre_sort_flatted_out and pulse snapshot_valid_out for exactly one cycle, the cycle after the terminal cycle; the snapshot holds until the next terminal cycle.
REQ-019 SHALL pulse sorted_valid_out exactly SORT_LATENCY cycles after snapshot_valid_out, via a SORT_LATENCY-deep valid shift register that runs regardless of enable_in.
REQ-020 SHALL give restart_in priority over the terminal cycle and access: clear hit and epoch counters; no snapshot, no pulse; snapshot register and in-flight valid shift unchanged.
REQ-021 SHALL, when an access hits a counter already at 2^W-1 on the terminal cycle, snapshot 2^W-1.
REQ-022 SHALL produce back-to-back epochs with no dead cycle: the cycle after the terminal cycle counts as epoch cycle 0.

Reset
REQ-023 SHALL, while reset_in=1 at a clock edge, clear all hit counters, the epoch counter, the snapshot register (pre_sort_flatted_out=0) and the valid shift register (snapshot_valid_out=0, sorted_valid_out=0).
REQ-024 SHALL, on reset mid-epoch or with a valid in flight, discard all of it; no pulse emerges after reset release.

Structure
REQ-025 SHALL take SINGLE_WAY_WIDTH_IN_BITS, NUM_WAY and SORT_LATENCY defaults from the shared sorter constants package, so profiler and sorter widths/latency cannot diverge.
REQ-026 SHALL implement one saturating counter as sub-module way_hit_counter (inc, clear, hold), instantiated NUM_WAY times by generate.

Verification (EPOCH_CYCLES=16, W=4, NUM_WAY=16, SORT_LATENCY=3)
REQ-027 SHALL check: enable=1, 5 hits to way 3, 2 to way 9 in epoch -> snapshot_valid_out pulse at cycle 16, way3=5, way9=2, other ways 0; sorted_valid_out pulse at cycle 19.
REQ-028 SHALL check: hit way 7 every cycle of an epoch (16 hits) -> way7 snapshot = 15 (saturated).
REQ-029 SHALL check: enable_in low for 10 cycles mid-epoch with accesses present -> those accesses uncounted; snapshot pulse delayed by exactly 10 cycles.
REQ-030 SHALL check: restart_in asserted on the terminal cycle -> no snapshot_valid_out, previous snapshot held, next pulse 16 enabled cycles later.
REQ-031 SHALL check: reset_in 1 cycle after snapshot_valid_out -> sorted_valid_out never pulses; pre_sort_flatted_out=0.
REQ-032 SHALL check: hit to way 0 on the terminal cycle and on the next cycle -> snapshot way0 includes the first; the next epoch starts with way0=1.

Source files
------------

// File: rtl/way_hit_profiler_pkg.sv
// Constants shared by the way-hit profiler and the downstream way sorter, so
// that both sides always agree on count width, way count and sort latency.
package way_hit_profiler_pkg;

  localparam int unsigned SorterWayWidth = 4;
  localparam int unsigned SorterNumWay   = 16;
  localparam int unsigned SorterLatency  = 3;

endpackage

// File: rtl/way_hit_profiler_counter.sv
// One per-way saturating hit counter. count_next_o is the value after this
// cycle's increment (ignoring clear), so the top can snapshot it directly.
module way_hit_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [Width-1:0] count_next_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_next_o = count_q;
    if (inc_i && !(&count_q)) begin
      count_next_o = count_q + Width'(1);
    end
    count_d = clear_i ? '0 : count_next_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/way_hit_profiler.sv
// Counts cache hits per way over fixed epochs of enabled cycles, then hands a
// snapshot of all counts to the sorter together with its valid timing.
module way_hit_profiler
  import way_hit_profiler_pkg::*;
#(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = SorterWayWidth,
  parameter int unsigned NUM_WAY                  = SorterNumWay,
  parameter int unsigned EPOCH_CYCLES             = 1024,
  parameter int unsigned SORT_LATENCY             = SorterLatency
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic                                        access_valid_in,
  input  logic [$clog2(NUM_WAY)-1:0]                  access_way_in,
  input  logic                                        enable_in,
  input  logic                                        restart_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] pre_sort_flatted_out,
  output logic                                        snapshot_valid_out,
  output logic                                        sorted_valid_out
);

  localparam int unsigned W       = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int unsigned WayIdxW = $clog2(NUM_WAY);
  localparam int unsigned EpochW  = (EPOCH_CYCLES > 2) ? $clog2(EPOCH_CYCLES) : 1;
  localparam logic [EpochW-1:0] LastEpoch = EpochW'(EPOCH_CYCLES - 1);

  logic [EpochW-1:0]    epoch_q, epoch_d;
  logic [W*NUM_WAY-1:0] snapshot_q, snapshot_d;
  logic                 snapshot_valid_q;
  logic [SORT_LATENCY-1:0] sort_pipe_q, sort_pipe_d;

  logic                 terminal;
  logic                 hit_en;
  logic                 clear_counts;
  logic [W-1:0]         way_next [NUM_WAY];

  // Restart outranks the terminal cycle, so a restarted epoch never snapshots.
  assign terminal     = enable_in && !restart_in && (epoch_q == LastEpoch);
  assign hit_en       = access_valid_in && enable_in;
  assign clear_counts = restart_in || terminal;

  for (genvar g = 0; g < NUM_WAY; g++) begin : g_way
    way_hit_counter #(
      .Width(W)
    ) u_way_hit_counter (
      .clk_i       (clk_in),
      .reset_i     (reset_in),
      .inc_i       (hit_en && (access_way_in == WayIdxW'(g))),
      .clear_i     (clear_counts),
      .count_next_o(way_next[g])
    );
  end

  always_comb begin
    epoch_d = epoch_q;
    if (restart_in || terminal) begin
      epoch_d = '0;
    end else if (enable_in) begin
      epoch_d = epoch_q + EpochW'(1);
    end
  end

  always_comb begin
    snapshot_d = snapshot_q;
    if (terminal) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        snapshot_d[i*W +: W] = way_next[i];
      end
    end
  end

  // Valid delay line models the sorter's register stages; it ignores enable.
  always_comb begin
    sort_pipe_d    = sort_pipe_q;
    sort_pipe_d[0] = snapshot_valid_q;
    for (int i = 1; i < SORT_LATENCY; i++) begin
      sort_pipe_d[i] = sort_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      epoch_q          <= '0;
      snapshot_q       <= '0;
      snapshot_valid_q <= 1'b0;
      sort_pipe_q      <= '0;
    end else begin
      epoch_q          <= epoch_d;
      snapshot_q       <= snapshot_d;
      snapshot_valid_q <= terminal;
      sort_pipe_q      <= sort_pipe_d;
    end
  end

  assign pre_sort_flatted_out = snapshot_q;
  assign snapshot_valid_out   = snapshot_valid_q;
  assign sorted_valid_out     = sort_pipe_q[SORT_LATENCY-1];

endmodule

// File: tb/tb_way_hit_profiler.sv
// Directed epoch scenarios plus random traffic, checked every cycle against
// an epoch-level model of hit totals, snapshots and pulse times.
module tb_way_hit_profiler;

  localparam int Epoch = 16;
  localparam int NWay  = 16;
  localparam int Wd    = 4;
  localparam int Lat   = 3;
  localparam int Sat   = (1 << Wd) - 1;

  logic            clk_in = 1'b0;
  logic            reset_in = 1'b1;
  logic            access_valid_in = 1'b0;
  logic [3:0]      access_way_in = '0;
  logic            enable_in = 1'b0;
  logic            restart_in = 1'b0;
  logic [63:0]     pre_sort_flatted_out;
  logic            snapshot_valid_out;
  logic            sorted_valid_out;

  int total = 0;
  int bad   = 0;

  // Reference model state: raw (unbounded) hit totals per way this epoch.
  int hits [NWay];
  int snap [NWay];
  int epoch_pos;
  int cyc;
  bit exp_sv;
  bit exp_sorted;
  int sorted_due [$];

  way_hit_profiler #(
    .EPOCH_CYCLES(Epoch)
  ) u_dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .access_valid_in     (access_valid_in),
    .access_way_in       (access_way_in),
    .enable_in           (enable_in),
    .restart_in          (restart_in),
    .pre_sort_flatted_out(pre_sort_flatted_out),
    .snapshot_valid_out  (snapshot_valid_out),
    .sorted_valid_out    (sorted_valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_flat();
    logic [63:0] f = '0;
    for (int i = 0; i < NWay; i++) f[i*Wd +: Wd] = 4'(snap[i]);
    return f;
  endfunction

  task automatic model(input bit v, input int w, input bit en, input bit rs, input bit rst);
    cyc++;
    exp_sv = 1'b0;
    if (rst) begin
      for (int i = 0; i < NWay; i++) begin
        hits[i] = 0;
        snap[i] = 0;
      end
      epoch_pos = 0;
      sorted_due.delete();
    end else if (rs) begin
      for (int i = 0; i < NWay; i++) hits[i] = 0;
      epoch_pos = 0;
    end else if (en) begin
      if (v) hits[w]++;
      if (epoch_pos == Epoch - 1) begin
        for (int i = 0; i < NWay; i++) begin
          snap[i] = (hits[i] > Sat) ? Sat : hits[i];
          hits[i] = 0;
        end
        epoch_pos = 0;
        exp_sv = 1'b1;
        sorted_due.push_back(cyc + Lat);
      end else begin
        epoch_pos++;
      end
    end
    exp_sorted = 1'b0;
    if (sorted_due.size() > 0 && sorted_due[0] == cyc) begin
      exp_sorted = 1'b1;
      void'(sorted_due.pop_front());
    end
  endtask

  task automatic step(input bit v, input int w, input bit en, input bit rs, input bit rst);
    access_valid_in = v;
    access_way_in   = 4'(w);
    enable_in       = en;
    restart_in      = rs;
    reset_in        = rst;
    @(posedge clk_in);
    model(v, w, en, rs, rst);
    #1;
    check("snapshot_valid", 64'(snapshot_valid_out), 64'(exp_sv));
    check("sorted_valid", 64'(sorted_valid_out), 64'(exp_sorted));
    check("snapshot_data", pre_sort_flatted_out, exp_flat());
  endtask

  task automatic idle_en(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < NWay; i++) begin
      hits[i] = 0;
      snap[i] = 0;
    end
    epoch_pos = 0;
    cyc = 0;
    #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_flat", pre_sort_flatted_out, 64'h0);
    check("reset_sorted", 64'(sorted_valid_out), 64'h0);

    // 5 hits to way 3, 2 to way 9, then fill out the epoch.
    for (int i = 0; i < 5; i++) step(1, 3, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 9, 1, 0, 0);
    idle_en(9);
    check("e1_pulse", 64'(snapshot_valid_out), 64'h1);
    check("e1_way3", 64'(pre_sort_flatted_out[3*4 +: 4]), 64'd5);
    check("e1_way9", 64'(pre_sort_flatted_out[9*4 +: 4]), 64'd2);
    check("e1_way0", 64'(pre_sort_flatted_out[3:0]), 64'd0);
    for (int i = 0; i < Lat; i++) step(0, 0, 0, 0, 0);
    check("e1_sorted", 64'(sorted_valid_out), 64'h1);

    // Saturation: way 7 every cycle of an epoch.
    for (int i = 0; i < Epoch; i++) step(1, 7, 1, 0, 0);
    check("sat_way7", 64'(pre_sort_flatted_out[7*4 +: 4]), 64'd15);

    // Disabled stretch with accesses present delays the epoch by 10.
    for (int i = 0; i < 5; i++) step(1, 2, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 2, 0, 0, 0);
    idle_en(10);
    check("dis_no_early", 64'(snapshot_valid_out), 64'h0);
    idle_en(1);
    check("dis_pulse", 64'(snapshot_valid_out), 64'h1);
    check("dis_way2", 64'(pre_sort_flatted_out[2*4 +: 4]), 64'd5);

    // Restart on the terminal cycle.
    for (int i = 0; i < Epoch - 1; i++) step(1, 4, 1, 0, 0);
    step(1, 4, 1, 1, 0);
    check("rst_term_nopulse", 64'(snapshot_valid_out), 64'h0);
    check("rst_term_held", 64'(pre_sort_flatted_out[2*4 +: 4]), 64'd5);
    idle_en(Epoch);
    check("rst_term_next", 64'(snapshot_valid_out), 64'h1);

    // Reset right after a pulse kills the in-flight sorted valid.
    idle_en(Epoch);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < Lat + 2; i++) step(0, 0, 0, 0, 0);
    check("rst_flight_flat", pre_sort_flatted_out, 64'h0);

    // Hit way 0 on the terminal cycle and the one after.
    idle_en(Epoch - 1);
    step(1, 0, 1, 0, 0);
    check("t0_way0", 64'(pre_sort_flatted_out[3:0]), 64'd1);
    step(1, 0, 1, 0, 0);
    idle_en(Epoch - 1);
    check("t1_way0", 64'(pre_sort_flatted_out[3:0]), 64'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, NWay - 1)),
           bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 99) == 0),
           bit'($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
